// File: rtl/ahb_master_ctrl.sv
// AHB master sequencer: arbitrates between the instruction-fetch and data
// clients, runs the HBUSREQ/HGRANT handshake, issues single NONSEQ transfers
// and returns completion (plus read data) to whichever client was chosen.
module ahb_master_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4,   // 1..15
  parameter int RETRY_MAX  = 7    // 1..15
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  // AHB master port
  output logic              HBUSREQ,
  output logic              HLOCK,
  input  logic              HGRANT,
  input  logic              HREADY,
  input  logic [1:0]        HRESP,
  output logic [1:0]        HTRANS,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  // instruction-fetch client (read-only, word sized)
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  // data-memory client
  input  logic              dm_req,
  input  logic              dm_write,
  input  logic [2:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  // qualifies if_done/dm_done: the transfer failed
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ADDR = 2'd2,
    S_DATA = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_ERROR   = 2'b01;
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [2:0] SIZE_WORD    = 3'b010;
  localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIM);
  localparam logic [3:0] RETRY_MAX_C  = 4'(RETRY_MAX);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic [2:0]          size_q, size_d;
  logic                owner_dm_q, owner_dm_d;
  logic [3:0]          starve_q, starve_d;
  logic [3:0]          retry_q, retry_d;
  logic                if_done_q, if_done_d;
  logic                dm_done_q, dm_done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic any_req;
  logic dm_wins;
  logic resp_ok;
  logic resp_err;
  logic give_up;

  assign any_req  = if_req | dm_req;
  // IF is forced through only once DM has won STARVE_LIM times in a row.
  assign dm_wins  = dm_req & ~(if_req & (starve_q == STARVE_LIM_C));
  assign resp_ok  = (HRESP == RESP_OKAY);
  assign resp_err = (HRESP == RESP_ERROR);
  // RETRY/SPLIT with the re-issue budget already spent is reported as a failure.
  assign give_up  = resp_ok | resp_err | (retry_q == RETRY_MAX_C);

  // State register.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: request, grant wait, address phase, data phase.
  // NOTE: every combinational output gets a default first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (any_req)           state_d = S_REQ;
      S_REQ:  if (HGRANT && HREADY)  state_d = S_ADDR;
      S_ADDR: if (HREADY)            state_d = S_DATA;
      S_DATA: if (HREADY)            state_d = give_up ? S_IDLE : S_REQ;
      default:                       state_d = S_IDLE;
    endcase
  end

  // Bus outputs follow the state; attributes always come from the latched copy.
  always_comb begin
    HBUSREQ = 1'b0;
    HTRANS  = TRANS_IDLE;
    HWDATA  = '0;
    unique case (state_q)
      S_REQ:  HBUSREQ = 1'b1;
      S_ADDR: begin
        HBUSREQ = 1'b1;
        HTRANS  = TRANS_NONSEQ;
      end
      S_DATA: if (write_q) HWDATA = wdata_q;
      default: ;
    endcase
  end

  assign HLOCK    = 1'b0;
  assign HBURST   = 3'b000;
  assign HADDR    = addr_q;
  assign HWRITE   = write_q;
  assign HSIZE    = size_q;
  assign if_done  = if_done_q;
  assign dm_done  = dm_done_q;
  assign if_rdata = rdata_q;
  assign dm_rdata = rdata_q;
  assign err      = err_q;

  // Transfer bookkeeping: client selection, starvation/retry counters, completion.
  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    size_d     = size_q;
    owner_dm_d = owner_dm_q;
    starve_d   = starve_q;
    retry_d    = retry_q;
    rdata_d    = rdata_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    err_d      = 1'b0;

    if (state_q == S_IDLE && any_req) begin
      if (dm_wins) begin
        owner_dm_d = 1'b1;
        addr_d     = dm_addr;
        wdata_d    = dm_wdata;
        write_d    = dm_write;
        size_d     = dm_size;
        if (if_req && starve_q != STARVE_LIM_C) starve_d = starve_q + 4'd1;
      end else begin
        owner_dm_d = 1'b0;
        addr_d     = if_addr;
        wdata_d    = '0;
        write_d    = 1'b0;
        size_d     = SIZE_WORD;
        starve_d   = '0;
      end
    end

    if (state_q == S_DATA && HREADY) begin
      if (give_up) begin
        if_done_d = ~owner_dm_q;
        dm_done_d = owner_dm_q;
        err_d     = ~resp_ok;
        rdata_d   = resp_ok ? HRDATA : '0;
        retry_d   = '0;
      end else begin
        retry_d   = retry_q + 4'd1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
      owner_dm_q <= 1'b0;
      starve_q   <= '0;
      retry_q    <= '0;
      rdata_q    <= '0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      size_q     <= size_d;
      owner_dm_q <= owner_dm_d;
      starve_q   <= starve_d;
      retry_q    <= retry_d;
      rdata_q    <= rdata_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// Bench for ahb_master_ctrl: transaction-level reference model, per-cycle
// compare on the falling edge, directed scenarios and a randomized run.
`timescale 1ns/1ps
module tb_ahb_master_ctrl;

  localparam int STARVE_LIM = 4;
  localparam int RETRY_MAX  = 7;
  localparam logic [1:0] OKAY = 2'b00, ERROR = 2'b01, RETRY = 2'b10, SPLIT = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HBUSREQ, HLOCK, HWRITE;
  logic        HGRANT = 1'b1, HREADY = 1'b1;
  logic [1:0]  HRESP = OKAY, HTRANS;
  logic [31:0] HADDR, HWDATA, HRDATA = '0;
  logic [2:0]  HSIZE, HBURST;
  logic        if_req = 1'b0, if_done;
  logic [31:0] if_addr = '0, if_rdata;
  logic        dm_req = 1'b0, dm_write = 1'b0, dm_done, err;
  logic [2:0]  dm_size = 3'b010;
  logic [31:0] dm_addr = '0, dm_wdata = '0, dm_rdata;

  always #5 HCLK = ~HCLK;

  ahb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(STARVE_LIM), .RETRY_MAX(RETRY_MAX)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK), .HGRANT(HGRANT),
    .HREADY(HREADY), .HRESP(HRESP), .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_write(dm_write), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata), .err(err));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one outstanding transfer) -------------
  // ph: 0 nothing in flight, 1 waiting for the bus, 2 address phase, 3 data phase
  int          ph;
  bit          m_dm, m_write, m_if_done, m_dm_done, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_size;
  int          m_starve, m_retries;

  function automatic void model_reset();
    ph = 0; m_dm = 0; m_write = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    m_size = '0; m_starve = 0; m_retries = 0;
    m_if_done = 0; m_dm_done = 0; m_err = 0;
  endfunction

  function automatic void model_finish(input bit failed, input logic [31:0] rd);
    m_if_done = !m_dm;
    m_dm_done = m_dm;
    m_err     = failed;
    m_rdata   = rd;
    m_retries = 0;
    ph        = 0;
  endfunction

  // Apply one rising edge using the inputs that were present before it.
  function automatic void model_edge();
    m_if_done = 0; m_dm_done = 0; m_err = 0;
    if (!HRESETn) begin
      model_reset();
      return;
    end
    case (ph)
      0: if (if_req || dm_req) begin
        if (dm_req && !(if_req && m_starve == STARVE_LIM)) begin
          m_dm = 1; m_addr = dm_addr; m_write = dm_write; m_size = dm_size; m_wdata = dm_wdata;
          if (if_req) m_starve = (m_starve < STARVE_LIM) ? m_starve + 1 : STARVE_LIM;
        end else begin
          m_dm = 0; m_addr = if_addr; m_write = 0; m_size = 3'b010; m_starve = 0;
        end
        ph = 1;
      end
      1: if (HGRANT && HREADY) ph = 2;
      2: if (HREADY) ph = 3;
      3: if (HREADY) begin
        if (HRESP == OKAY)                               model_finish(0, HRDATA);
        else if (HRESP == ERROR || m_retries == RETRY_MAX) model_finish(1, '0);
        else begin
          m_retries++;
          ph = 1;
        end
      end
      default: ph = 0;
    endcase
  endfunction

  // Per-cycle comparison of the DUT against the model.
  always @(negedge HCLK) begin
    check("busreq", HBUSREQ, (ph == 1 || ph == 2));
    check("htrans", HTRANS, (ph == 2) ? 2'b10 : 2'b00);
    check("hlock", HLOCK, 1'b0);
    check("hburst", HBURST, 3'b000);
    if (ph == 2) begin
      check("haddr", HADDR, m_addr);
      check("hwrite", HWRITE, m_write);
      check("hsize", HSIZE, m_size);
    end
    if (ph == 3 && m_write) check("hwdata", HWDATA, m_wdata);
    check("if_done", if_done, m_if_done);
    check("dm_done", dm_done, m_dm_done);
    check("err", err, m_err);
    if (m_if_done && !m_err) check("if_rdata", if_rdata, m_rdata);
    if (m_dm_done && !m_err) check("dm_rdata", dm_rdata, m_rdata);
  end

  // ---------------- stimulus knobs and drivers -----------------------------
  bit          k_grant_rand = 0, k_hold = 0, k_rand_clients = 0, k_rdata_rand = 1;
  int          k_ready_pct = 100, k_waits = 0, k_err_pct = 0;
  logic [31:0] k_rdata = '0;
  logic [1:0]  resp_q[$];
  bit          dp_active;
  int          dcnt, dwaits;
  logic [1:0]  dresp;
  int          dut_order[$];   // 1 = DM completion, 0 = IF completion
  logic        dut_err[$];
  logic [31:0] issue_addr[$];

  task automatic drive_slave();
    if (ph == 3) begin
      if (!dp_active) begin
        dp_active = 1;
        dcnt = 0;
        if (resp_q.size() > 0) dresp = resp_q.pop_front();
        else if (int'($urandom_range(99)) < k_err_pct) dresp = 2'($urandom_range(3, 1));
        else dresp = OKAY;
        dwaits = (k_waits < 0) ? int'($urandom_range(3)) : k_waits;
        if (dresp != OKAY && dwaits == 0) dwaits = 1;
      end
      if (dcnt < dwaits) begin
        HREADY = 1'b0;
        HRESP  = (dcnt == dwaits - 1) ? dresp : OKAY;
        HRDATA = $urandom;
      end else begin
        HREADY = 1'b1;
        HRESP  = dresp;
        HRDATA = k_rdata_rand ? $urandom : k_rdata;
      end
      dcnt++;
    end else begin
      dp_active = 0;
      HREADY = (int'($urandom_range(99)) < k_ready_pct);
      HRESP  = OKAY;
    end
    // The arbiter only moves the grant on a cycle that ends with HREADY high.
    if (!k_grant_rand)  HGRANT = 1'b1;
    else if (HREADY)    HGRANT = ($urandom_range(3) != 0);
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
    model_edge();
    if (if_done) dut_order.push_back(0);
    if (dm_done) dut_order.push_back(1);
    if (if_done || dm_done) dut_err.push_back(err);
    if (!k_hold) begin
      if (m_if_done) if_req = 1'b0;
      if (m_dm_done) dm_req = 1'b0;
    end
    if (k_rand_clients) begin
      if (!if_req && !m_if_done && $urandom_range(3) == 0) begin
        if_req  = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!dm_req && !m_dm_done && $urandom_range(2) == 0) begin
        dm_req   = 1'b1;
        dm_write = 1'($urandom_range(1));
        dm_size  = 3'($urandom_range(2));
        dm_addr  = $urandom;
        dm_wdata = $urandom;
      end
    end
    drive_slave();
    if (HTRANS == 2'b10 && HREADY) issue_addr.push_back(HADDR);
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    model_reset();
    if_req = 1'b0; dm_req = 1'b0;
    HREADY = 1'b1; HGRANT = 1'b1; HRESP = OKAY;
    dp_active = 0;
    k_grant_rand = 0; k_hold = 0; k_rand_clients = 0; k_rdata_rand = 1;
    k_ready_pct = 100; k_waits = 0; k_err_pct = 0;
    resp_q.delete();
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    dut_order.delete(); dut_err.delete(); issue_addr.delete();
  endtask

  task automatic run_until_done(input int n, input string name);
    for (int i = 0; i < 200 && dut_order.size() < n; i++) step();
    check({name, "_done_seen"}, (dut_order.size() >= n), 1'b1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int exp_order[11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};

  initial begin
    model_reset();
    // Reset state.
    #3;
    check("rst_hbusreq", HBUSREQ, 1'b0);
    check("rst_htrans", HTRANS, 2'b00);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_dones", {if_done, dm_done, err}, 3'b000);

    // DM write, zero waits: NONSEQ in cycle 2, data in 3, done in 4.
    do_reset();
    dm_req = 1'b1; dm_write = 1'b1; dm_addr = 32'h0000_1000; dm_wdata = 32'hDEAD_BEEF; dm_size = 3'b010;
    step(); check("t1_c1_busreq", HBUSREQ, 1'b1); check("t1_c1_htrans", HTRANS, 2'b00);
    step(); check("t1_c2_htrans", HTRANS, 2'b10); check("t1_c2_haddr", HADDR, 32'h0000_1000);
            check("t1_c2_hwrite", HWRITE, 1'b1);
    step(); check("t1_c3_hwdata", HWDATA, 32'hDEAD_BEEF); check("t1_c3_dm_done", dm_done, 1'b0);
    step(); check("t1_c4_dm_done", dm_done, 1'b1); check("t1_c4_err", err, 1'b0);
    step(); check("t1_c5_dm_done", dm_done, 1'b0); check("t1_c5_busreq", HBUSREQ, 1'b0);

    // IF read with two data-phase wait states: done in cycle 6.
    do_reset();
    k_waits = 2; k_rdata_rand = 0; k_rdata = 32'h1234_5678;
    if_req = 1'b1; if_addr = 32'h0000_0040;
    step();
    step(); check("t2_c2_haddr", HADDR, 32'h0000_0040); check("t2_c2_hsize", HSIZE, 3'b010);
    step(); check("t2_c3_haddr_held", HADDR, 32'h0000_0040);
    step();
    step(); check("t2_c5_if_done", if_done, 1'b0);
    step(); check("t2_c6_if_done", if_done, 1'b1); check("t2_c6_rdata", if_rdata, 32'h1234_5678);
            check("t2_c6_err", err, 1'b0);
    k_rdata_rand = 1;

    // Both clients held: DM x4, IF, DM x4, IF, DM.
    do_reset();
    k_hold = 1;
    if_req = 1'b1; if_addr = 32'h80;
    dm_req = 1'b1; dm_write = 1'b0; dm_addr = 32'h400; dm_size = 3'b010;
    run_until_done(11, "t3");
    for (int i = 0; i < 11 && i < dut_order.size(); i++)
      check($sformatf("t3_order%0d", i), dut_order[i], exp_order[i]);

    // RETRY once, then OKAY: two identical address phases, one clean done.
    do_reset();
    resp_q = '{RETRY, OKAY};
    dm_req = 1'b1; dm_write = 1'b0; dm_addr = 32'h3000_0008; dm_size = 3'b010;
    run_until_done(1, "t4");
    repeat (3) step();
    check("t4_issues", issue_addr.size(), 2);
    foreach (issue_addr[i]) check($sformatf("t4_addr%0d", i), issue_addr[i], 32'h3000_0008);
    check("t4_done_count", dut_order.size(), 1);
    if (dut_err.size() > 0) check("t4_err", dut_err[0], 1'b0);

    // RETRY/SPLIT on every attempt: 8 attempts, then done with err.
    do_reset();
    resp_q = '{RETRY, SPLIT, RETRY, RETRY, SPLIT, RETRY, SPLIT, RETRY};
    dm_req = 1'b1; dm_write = 1'b1; dm_addr = 32'h0000_2000; dm_wdata = 32'h5A5A_0001;
    run_until_done(1, "t4b");
    repeat (3) step();
    check("t4b_issues", issue_addr.size(), 8);
    check("t4b_done_count", dut_order.size(), 1);
    if (dut_err.size() > 0) check("t4b_err", dut_err[0], 1'b1);

    // ERROR on a DM read: done with err, then back to idle.
    do_reset();
    resp_q = '{ERROR};
    dm_req = 1'b1; dm_write = 1'b0; dm_addr = 32'h44;
    run_until_done(1, "t5");
    if (dut_err.size() > 0) check("t5_err", dut_err[0], 1'b1);
    step(); check("t5_idle_busreq", HBUSREQ, 1'b0); check("t5_idle_htrans", HTRANS, 2'b00);

    // Reset asserted during the address phase: immediate reset values, no done.
    do_reset();
    dm_req = 1'b1; dm_write = 1'b1; dm_addr = 32'h55; dm_wdata = 32'h77;
    step();
    step(); check("t6_in_addr", HTRANS, 2'b10);
    #1;
    HRESETn = 1'b0;
    model_reset();
    dm_req = 1'b0;
    #1;
    check("t6_rst_busreq", HBUSREQ, 1'b0); check("t6_rst_htrans", HTRANS, 2'b00);
    check("t6_rst_haddr", HADDR, 32'h0); check("t6_rst_hwrite", HWRITE, 1'b0);
    check("t6_rst_hsize", HSIZE, 3'b000);
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    repeat (5) step();
    check("t6_no_done", dut_order.size(), 0);

    // Randomized traffic with a reset in the middle.
    do_reset();
    k_grant_rand = 1; k_ready_pct = 70; k_waits = -1; k_err_pct = 25; k_rand_clients = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        HRESETn = 1'b0;
        model_reset();
      end
      if (i == 1503) HRESETn = 1'b1;
      step();
    end
    check("rand_activity", (dut_order.size() > 50), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_master_ctrl.md
Name: ahb_master_ctrl

Overview:
Bus-side sequencer for the CPU's single AHB master port. It takes requests from two internal clients, instruction fetch (IF, read-only) and data memory (DM, read/write), and picks one. It then runs the HBUSREQ/HGRANT handshake with the system arbiter and drives single NONSEQ transfers through the AHB address and data phases. It handles wait states, ERROR, RETRY and SPLIT, and returns read data and completion to the chosen client.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIM, 4, consecutive DM wins after which IF is forced next (range 1-15)
RETRY_MAX, 7, RETRY/SPLIT re-issues before the transfer is failed (range 1-15)

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset; asynchronous, active-low
HBUSREQ  out  1  bus request to arbiter
HLOCK  out  1  tied 0; no locked transfers
HGRANT  in  1  grant from arbiter
HREADY  in  1  transfer ready
HRESP  in  `AHB_RESP_BITS  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT
HTRANS  out  `AHB_TRANS_BITS  00 IDLE, 10 NONSEQ
HADDR  out  ADDR_W  address
HWRITE  out  1  write
HSIZE  out  3  transfer size
HBURST  out  3  tied 000 (SINGLE)
HWDATA  out  DATA_W  write data, data phase
HRDATA  in  DATA_W  read data
if_req  in  1  IF request, held until if_done
if_addr  in  ADDR_W  IF address; size fixed to word (010)
if_done  out  1  one-cycle completion pulse
if_rdata  out  DATA_W  fetched data, valid with if_done
dm_req  in  1  DM request, held until dm_done
dm_write, dm_size[2:0], dm_addr, dm_wdata  in  DM transfer attributes
dm_done  out  1  one-cycle completion pulse
dm_rdata  out  DATA_W  read data, valid with dm_done
err  out  1  with if_done/dm_done: transfer failed

Behaviour:
- Reset values: HBUSREQ=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, all done/err=0, state=IDLE, counters=0. Reset mid-transfer abandons the transfer and issues no done.
- Selection in IDLE when any req=1:
  - DM wins if dm_req=1, unless starve_cnt==STARVE_LIM and if_req=1, in which case IF wins.
  - starve_cnt increments on each DM win while if_req=1, saturating at STARVE_LIM. It clears on any IF win.
  - The winner's addr, size, write and wdata are latched, and that latched copy drives the bus. Client inputs are ignored after selection.
- States:
  - IDLE: any req -> REQ.
  - REQ: HBUSREQ=1, HTRANS=IDLE. At an edge with HGRANT&HREADY -> ADDR.
  - ADDR: HBUSREQ=1, HTRANS=NONSEQ, HADDR/HWRITE/HSIZE from the latch. At an edge with HREADY -> DATA; without HREADY, hold every signal.
  - DATA: HBUSREQ=0, HTRANS=IDLE, HWDATA=latched wdata (writes). Exits only at an edge with HREADY=1:
    - OKAY: done=1 and rdata=HRDATA (captured) in the next cycle, err=0 -> IDLE.
    - ERROR: done=1, err=1 -> IDLE.
    - RETRY or SPLIT: retry_cnt+1 -> REQ, re-issuing the same latched transfer. If retry_cnt was already RETRY_MAX, instead done=1, err=1 -> IDLE.
  - A first-cycle HRESP!=OKAY with HREADY=0 in DATA is only a wait; the outcome is decided on the HREADY=1 cycle.
- Done/err are registered and last exactly one cycle. retry_cnt clears on entry to IDLE.
- Earliest single transfer, zero wait states: req at cycle 0, REQ at 1, ADDR at 2, DATA at 3, done at 4.
- A grant lost while in REQ leaves the block waiting in REQ. ADDR is entered only with grant, and a grant cannot change while HREADY=0.
- The block may re-select on the cycle after done. A client must drop its req on or before the cycle it sees done, or it is treated as a new request.
- Simultaneous if_req and dm_req with starve_cnt<STARVE_LIM: DM is served and if_req stays pending.

Test Plan:
- DM write, addr 0x0000_1000, wdata 0xDEAD_BEEF, size 010, HGRANT tied 1, HREADY=1 -> NONSEQ in cycle 2, HWDATA=0xDEADBEEF in cycle 3, dm_done in cycle 4, err=0.
- IF read with 2 HREADY wait states in the data phase, HRDATA=0x1234_5678 -> if_rdata=0x12345678 with if_done 2 cycles later than the zero-wait case; HADDR held.
- if_req and dm_req held continuously, STARVE_LIM=4 -> grant order DM,DM,DM,DM,IF,DM...
- HRESP=RETRY (2-cycle response) on the first attempt, then OKAY -> transfer re-issued from REQ with identical HADDR; single done, err=0. RETRY on every attempt -> done with err=1 after RETRY_MAX+1 attempts.
- HRESP=ERROR on a DM read -> dm_done=1, err=1, state IDLE; HRESETn asserted during ADDR -> all outputs at reset values immediately, no done.
